stream_mux_reg: RTL and testbench
=================================

Name: stream_mux_reg

Overview:
- Parametrised successor to the team's fixed 2:1 32-bit word mux.
- Selects one of N W-bit valid/ready input streams into a single registered output stream.
- Channel choice is made either by an external select or by an internal round-robin arbiter.
- Sits between the SHA message-schedule/working-register sources and the compression datapath; one pipeline stage, full throughput.

Parameters:
- WIDTH, 32, data width per channel in bits
- N, 4, number of input channels (2..16)
- RR_MODE, 0, 0 = external select drives the grant; 1 = internal round-robin arbitration, sel ignored
- SEL_W, $clog2(N), localparam, width of select/channel fields

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- sel  in  SEL_W  external channel select (RR_MODE=0 only)
- in_valid  in  N  per-channel valid
- in_data  in  N*WIDTH  packed channel data, channel i at [i*WIDTH +: WIDTH]
- in_last  in  N  per-channel end-of-packet marker
- in_ready  out  N  per-channel ready
- out_valid  out  1  output register holds a beat
- out_data  out  WIDTH  registered data
- out_last  out  1  registered last flag
- out_chan  out  SEL_W  source channel of the current output beat
- out_ready  in  1  downstream ready

Behaviour:
- Reset: single clock, synchronous active-high rst; on rst high at a rising edge, out_valid=0, out_data=0, out_last=0, out_chan=0, RR pointer=0, lock=0. Reset mid-transfer drops the held beat; no transfer is accepted in the reset cycle.
- Transfer: input beat accepted when in_valid[g] && in_ready[g]; output beat consumed when out_valid && out_ready.
- Load enable: ld = !out_valid || out_ready. in_ready[i] = ld && (i == grant) && grant_ok; other in_ready bits are 0. in_ready never depends on in_valid of the same channel (no combinational valid->ready loop).
- Latency: 1 cycle from acceptance to out_valid. Back-to-back beats need no bubble: simultaneous consume and accept reloads the register.
- Output register: if accept, it loads data/last/chan and sets out_valid=1. Else if consume, out_valid=0 and data holds its last value. out_data must stay stable while out_valid && !out_ready.
- RR_MODE=0: grant=sel, grant_ok=(sel<N). sel>=N means no channel is granted and all in_ready are 0.
- RR_MODE=1: grant = first channel with in_valid set, searching from ptr upward modulo N (wrap N-1 -> 0). grant_ok = |in_valid. After an accepted beat, ptr = (grant+1) mod N; ptr is otherwise unchanged.
- No beat is lost or duplicated under any out_ready pattern.

Optional Feature:
- Macro: STREAM_MUX_PKT_LOCK_EN.
- Defined:
  - Accepting a beat with in_last=0 sets lock and records lock_ch=grant.
  - While locked, grant=lock_ch and grant_ok=1; sel and the RR search are ignored, and ptr does not advance.
  - Accepting a beat with in_last=1 on lock_ch clears lock and advances ptr (RR_MODE=1).
  - rst clears lock.
- Undefined: in_last is passed through to out_last only; arbitration is per beat, and no lock state exists.

Decomposition:
- Package stream_mux_pkg holds:
  - mode constants MODE_SEL=0 and MODE_RR=1
  - function clog2_min1 (returns 1 for N=1)
- Sub-module rr_arbiter (params N; inputs req[N], ptr; outputs gnt_idx, gnt_any) holds the rotating priority search and is instantiated only under RR_MODE=1 via generate.
- Output register and lock logic stay in the top.

Test Plan:
- RR_MODE=0, N=4, sel=2, in_valid=4'b0100, in_data ch2=0xDEADBEEF, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=0xDEADBEEF, out_chan=2.
- RR_MODE=0, sel=5 with N=4, all in_valid=1 -> in_ready=0 every cycle; out_valid stays 0.
- RR_MODE=1, all four channels valid continuously, out_ready=1 -> out_chan sequence 0,1,2,3,0,1; one beat per cycle; no bubbles.
- Backpressure: out_ready=0 for 3 cycles with a beat held (0x12345678) -> out_data stable at 0x12345678; in_ready=0; after out_ready=1, the next beat loads in the same cycle.
- rst asserted while out_valid=1 and ptr=3 -> next cycle out_valid=0, out_data=0, ptr=0; the first grant after reset is channel 0.
- STREAM_MUX_PKT_LOCK_EN, RR_MODE=1: ch1 sends a 3-beat packet (last on beat 3) while ch2 is valid -> out_chan=1,1,1 then 2; without the macro -> out_chan=1,2,...

Source files
------------

// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg: shared constants and helpers for the stream_mux_reg slice.
// Mode encodings for RR_MODE and a clog2 that never returns 0.
package stream_mux_pkg;

  localparam int MODE_SEL = 0;
  localparam int MODE_RR  = 1;

  // Keeps select fields at least one bit wide even for a single channel
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_mux_reg_rr_arbiter.sv
// rr_arbiter: rotating-priority search over N requests starting at ptr.
// Pure combinational; the pointer register lives in the instantiating block.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N     = 4,
  parameter int SEL_W = clog2_min1(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_any
);

  logic [SEL_W-1:0] hi_idx;
  logic [SEL_W-1:0] lo_idx;
  logic             hi_any;
  logic             lo_any;

  // Two ascending passes: first requester at or above ptr, else the lowest one (the wrap case)
  always_comb begin
    hi_idx = '0;
    hi_any = 1'b0;
    lo_idx = '0;
    lo_any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!hi_any && req[i] && (SEL_W'(i) >= ptr)) begin
        hi_any = 1'b1;
        hi_idx = SEL_W'(i);
      end
      if (!lo_any && req[i]) begin
        lo_any = 1'b1;
        lo_idx = SEL_W'(i);
      end
    end
    gnt_idx = hi_any ? hi_idx : lo_idx;
    gnt_any = lo_any;
  end

endmodule

// File: rtl/stream_mux_reg.sv
// stream_mux_reg: N-way valid/ready stream mux into a single registered output stage.
// Optional packet lock (grant held until in_last) is enabled by defining STREAM_MUX_PKT_LOCK_EN.
module stream_mux_reg
  import stream_mux_pkg::*;
#(
  parameter  int WIDTH   = 32,
  parameter  int N       = 4,
  parameter  int RR_MODE = MODE_SEL,
  localparam int SEL_W   = clog2_min1(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SEL_W-1:0]   sel,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_last,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_last,
  output logic [SEL_W-1:0]   out_chan,
  input  logic               out_ready
);

  logic [SEL_W-1:0] arb_idx;
  logic             arb_any;
  logic [SEL_W-1:0] grant;
  logic             grant_ok;
  logic             ld;
  logic             accept;
  logic             g_valid;
  logic             g_last;
  logic [WIDTH-1:0] g_data;

  assign ld = !out_valid || out_ready;

  generate
    if (RR_MODE == MODE_RR) begin : g_rr
      logic [SEL_W-1:0] ptr;
      logic             ptr_adv;

      rr_arbiter #(.N(N), .SEL_W(SEL_W)) u_arb (
        .req     (in_valid),
        .ptr     (ptr),
        .gnt_idx (arb_idx),
        .gnt_any (arb_any)
      );

`ifdef STREAM_MUX_PKT_LOCK_EN
      // Only the closing beat of a packet moves the pointer on
      assign ptr_adv = accept && g_last;
`else
      assign ptr_adv = accept;
`endif

      always_ff @(posedge clk) begin
        if (rst)
          ptr <= '0;
        else if (ptr_adv)
          ptr <= (grant == SEL_W'(N - 1)) ? '0 : grant + SEL_W'(1);
      end
    end else begin : g_sel
      assign arb_idx = sel;
      assign arb_any = ({1'b0, sel} < (SEL_W + 1)'(N));
    end
  endgenerate

`ifdef STREAM_MUX_PKT_LOCK_EN
  logic             lock;
  logic [SEL_W-1:0] lock_ch;

  assign grant    = lock ? lock_ch : arb_idx;
  assign grant_ok = lock || arb_any;

  always_ff @(posedge clk) begin
    if (rst) begin
      lock    <= 1'b0;
      lock_ch <= '0;
    end else if (accept) begin
      lock    <= !g_last;
      lock_ch <= grant;
    end
  end
`else
  assign grant    = arb_idx;
  assign grant_ok = arb_any;
`endif

  // Constant-index decode of the granted channel keeps selects lint-clean for any N
  always_comb begin
    g_valid  = 1'b0;
    g_last   = 1'b0;
    g_data   = '0;
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      if (grant == SEL_W'(i)) begin
        g_valid     = in_valid[i];
        g_last      = in_last[i];
        g_data      = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = ld && grant_ok;
      end
    end
  end

  assign accept = g_valid && ld && grant_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_chan  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= g_data;
      out_last  <= g_last;
      out_chan  <= grant;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux_reg.sv
// tb_stream_mux_reg: directed checks of select mode (N=4 and N=3) and round-robin mode.
// Packet-lock expectations follow STREAM_MUX_PKT_LOCK_EN when it is defined.
module tb_stream_mux_reg;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] dat;
  logic [3:0]   lst;

  logic [1:0]  sel0;
  logic [3:0]  v0, r0;
  logic        ov0, ol0, ordy0;
  logic [31:0] od0;
  logic [1:0]  oc0;

  logic [1:0]  sel1;
  logic [3:0]  v1, r1;
  logic        ov1, ol1, ordy1;
  logic [31:0] od1;
  logic [1:0]  oc1;

  logic [1:0]  sel2;
  logic [2:0]  v2, r2;
  logic        ov2, ol2, ordy2;
  logic [31:0] od2;
  logic [1:0]  oc2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  stream_mux_reg #(.WIDTH(32), .N(4), .RR_MODE(0)) u_sel (
    .clk(clk), .rst(rst), .sel(sel0), .in_valid(v0), .in_data(dat), .in_last(lst),
    .in_ready(r0), .out_valid(ov0), .out_data(od0), .out_last(ol0), .out_chan(oc0),
    .out_ready(ordy0));

  stream_mux_reg #(.WIDTH(32), .N(4), .RR_MODE(1)) u_rr (
    .clk(clk), .rst(rst), .sel(sel1), .in_valid(v1), .in_data(dat), .in_last(lst),
    .in_ready(r1), .out_valid(ov1), .out_data(od1), .out_last(ol1), .out_chan(oc1),
    .out_ready(ordy1));

  stream_mux_reg #(.WIDTH(32), .N(3), .RR_MODE(0)) u_sel3 (
    .clk(clk), .rst(rst), .sel(sel2), .in_valid(v2), .in_data(dat[95:0]), .in_last(lst[2:0]),
    .in_ready(r2), .out_valid(ov2), .out_data(od2), .out_last(ol2), .out_chan(oc2),
    .out_ready(ordy2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0] exp_ch[6];
    logic [1:0] lk_ch[4];
    logic [3:0] lk_last[4];

    rst = 1'b1; dat = '0; lst = 4'b1111;
    sel0 = 2'd0; v0 = '0; ordy0 = 1'b1;
    sel1 = 2'd0; v1 = '0; ordy1 = 1'b1;
    sel2 = 2'd0; v2 = '0; ordy2 = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checkOutput("reset_ov0", ov0, 0);
    checkOutput("reset_od0", od0, 0);
    checkOutput("reset_ol0", ol0, 0);
    checkOutput("reset_oc0", oc0, 0);
    checkOutput("reset_ov1", ov1, 0);
    checkOutput("reset_ov2", ov2, 0);

    $display("[TB] select mode, sel=2");
    dat  = {32'h0, 32'hDEADBEEF, 32'h0, 32'h0};
    sel0 = 2'd2; v0 = 4'b0100;
    #1;
    checkOutput("sel2_ready", r0, 4'b0100);
    tick();
    checkOutput("sel2_ov", ov0, 1);
    checkOutput("sel2_od", od0, 32'hDEADBEEF);
    checkOutput("sel2_oc", oc0, 2);
    checkOutput("sel2_ol", ol0, 1);
    v0 = 4'b0000;
    tick();
    checkOutput("sel2_drain_ov", ov0, 0);

    $display("[TB] select out of range, N=3 sel=3");
    dat  = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
    sel2 = 2'd3; v2 = 3'b111;
    #1;
    checkOutput("oor_ready_a", r2, 3'b000);
    tick();
    checkOutput("oor_ov_a", ov2, 0);
    checkOutput("oor_ready_b", r2, 3'b000);
    tick();
    checkOutput("oor_ov_b", ov2, 0);
    sel2 = 2'd1;
    #1;
    checkOutput("n3_sel1_ready", r2, 3'b010);
    tick();
    checkOutput("n3_sel1_od", od2, 32'h11111111);
    checkOutput("n3_sel1_oc", oc2, 1);
    v2 = 3'b000;

    $display("[TB] round-robin, all channels valid");
    dat = {32'hA0000003, 32'hA0000002, 32'hA0000001, 32'hA0000000};
    exp_ch = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    v1 = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      #1;
      checkOutput($sformatf("rr_ready_%0d", k), r1, 4'b0001 << exp_ch[k]);
      tick();
      checkOutput($sformatf("rr_ov_%0d", k), ov1, 1);
      checkOutput($sformatf("rr_oc_%0d", k), oc1, exp_ch[k]);
      checkOutput($sformatf("rr_od_%0d", k), od1, 32'hA0000000 + exp_ch[k]);
    end
    v1 = 4'b0000;
    tick();
    checkOutput("rr_drain_ov", ov1, 0);

    $display("[TB] backpressure on select mode");
    dat  = {32'h0, 32'h0, 32'h12345678, 32'h0};
    sel0 = 2'd1; v0 = 4'b0010;
    tick();
    checkOutput("bp_first_od", od0, 32'h12345678);
    ordy0 = 1'b0;
    dat   = {32'h0, 32'h0, 32'h0BADF00D, 32'h0};
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput($sformatf("bp_ready_%0d", k), r0, 4'b0000);
      tick();
      checkOutput($sformatf("bp_ov_%0d", k), ov0, 1);
      checkOutput($sformatf("bp_od_%0d", k), od0, 32'h12345678);
    end
    ordy0 = 1'b1;
    #1;
    checkOutput("bp_release_ready", r0, 4'b0010);
    tick();
    checkOutput("bp_reload_ov", ov0, 1);
    checkOutput("bp_reload_od", od0, 32'h0BADF00D);
    v0 = 4'b0000;
    tick();
    checkOutput("bp_drain_ov", ov0, 0);

    $display("[TB] reset while holding a beat, ptr=3");
    dat = {32'hC0000003, 32'hC0000002, 32'hC0000001, 32'hC0000000};
    v1  = 4'b1111;
    tick();
    checkOutput("pre_rst_oc", oc1, 2);
    checkOutput("pre_rst_ov", ov1, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rst_ov", ov1, 0);
    checkOutput("rst_od", od1, 0);
    checkOutput("rst_oc", oc1, 0);
    #1;
    checkOutput("post_rst_ready", r1, 4'b0001);
    tick();
    checkOutput("post_rst_oc", oc1, 0);
    checkOutput("post_rst_od", od1, 32'hC0000000);
    v1 = 4'b0000;
    tick();

    $display("[TB] packet on ch1 competing with ch2");
    dat = {32'h0, 32'hB2000000, 32'hB1000000, 32'h0};
`ifdef STREAM_MUX_PKT_LOCK_EN
    lk_ch   = '{2'd1, 2'd1, 2'd1, 2'd2};
    lk_last = '{4'b1101, 4'b1101, 4'b1111, 4'b1111};
`else
    lk_ch   = '{2'd1, 2'd2, 2'd1, 2'd2};
    lk_last = '{4'b1101, 4'b1101, 4'b1111, 4'b1111};
`endif
    v1 = 4'b0110;
    for (int k = 0; k < 4; k++) begin
      lst = lk_last[k];
      tick();
      checkOutput($sformatf("pkt_oc_%0d", k), oc1, lk_ch[k]);
      checkOutput($sformatf("pkt_od_%0d", k), od1, (lk_ch[k] == 2'd1) ? 32'hB1000000 : 32'hB2000000);
    end
    v1  = 4'b0000;
    lst = 4'b1111;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
